// File: rtl/cpu_dbg_pkg.sv
// Shared debug-controller definitions: run-mode encoding used by the step
// controller and the display/LED logic.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        ModeHalt    = 2'd0,
        ModeRunSlow = 2'd1,
        ModeRunFast = 2'd2
    } mode_e;

    // Mode button cycles HALT -> RUN_SLOW -> RUN_FAST -> HALT.
    function automatic mode_e next_mode(input mode_e cur);
        case (cur)
            ModeHalt:    return ModeRunSlow;
            ModeRunSlow: return ModeRunFast;
            default:     return ModeHalt;
        endcase
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Button, breakpoint and CPU-enable signals between the step controller and
// its environment (the controller is the slave side).
interface cpu_step_ctrl_if;

    logic        btn_step_n;
    logic        btn_mode_n;
    logic [15:0] cpu_addr;
    logic [15:0] bp_addr;
    logic        bp_en;
    logic        cpu_rdy;
    logic [1:0]  mode;
    logic        bp_hit;
    logic [15:0] pulse_count;

    modport master (
        output btn_step_n, btn_mode_n, cpu_addr, bp_addr, bp_en,
        input  cpu_rdy, mode, bp_hit, pulse_count
    );

    modport slave (
        input  btn_step_n, btn_mode_n, cpu_addr, bp_addr, bp_en,
        output cpu_rdy, mode, bp_hit, pulse_count
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer, level debouncer and press-event generator for one
// active-low push button.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive synchronized samples that disagree with the
    // accepted level; any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Single-step / free-run controller for a CPU RDY input, with a mode button,
// a step button and an address breakpoint.
module cpu_step_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SLOW_DIV        = 12500000,
    parameter int unsigned FAST_DIV        = 25
) (
    input logic            clk,
    input logic            rst,
    cpu_step_ctrl_if.slave bus
);

    localparam int unsigned DivMax = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int unsigned DivW   = $clog2(DivMax) + 1;
    localparam logic [DivW-1:0] SlowLast = DivW'(SLOW_DIV - 1);
    localparam logic [DivW-1:0] FastLast = DivW'(FAST_DIV - 1);

    logic            step_press, mode_press;
    mode_e           state_q, state_d;
    logic [DivW-1:0] div_q, div_d, div_last;
    logic            mask_q, mask_d;
    logic            cpu_rdy_q, cpu_rdy_d;
    logic            bp_hit_q, bp_hit_d;
    logic [15:0]     pulse_count_q, pulse_count_d;
    logic            bp_match;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk    (clk),
        .rst    (rst),
        .btn_n_i(bus.btn_step_n),
        .press_o(step_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_db (
        .clk    (clk),
        .rst    (rst),
        .btn_n_i(bus.btn_mode_n),
        .press_o(mode_press)
    );

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        mask_d    = mask_q;
        bp_hit_d  = bp_hit_q;
        cpu_rdy_d = 1'b0;
        div_last  = (state_q == ModeRunFast) ? FastLast : SlowLast;
        // The mask lets a run resume from the breakpoint address itself.
        bp_match  = bus.bp_en && (bus.cpu_addr == bus.bp_addr) && !mask_q;

        if (mode_press) begin
            state_d  = next_mode(state_q);
            div_d    = '0;
            mask_d   = 1'b1;
            bp_hit_d = 1'b0;
        end else if (state_q == ModeHalt) begin
            cpu_rdy_d = step_press;
        end else if (bp_match) begin
            state_d  = ModeHalt;
            bp_hit_d = 1'b1;
            div_d    = '0;
            mask_d   = 1'b1;
        end else if (div_q == div_last) begin
            cpu_rdy_d = 1'b1;
            div_d     = '0;
            mask_d    = 1'b0;
        end else begin
            div_d = div_q + 1'b1;
        end

        pulse_count_d = pulse_count_q + {15'd0, cpu_rdy_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ModeHalt;
            div_q         <= '0;
            mask_q        <= 1'b1;
            cpu_rdy_q     <= 1'b0;
            bp_hit_q      <= 1'b0;
            pulse_count_q <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            mask_q        <= mask_d;
            cpu_rdy_q     <= cpu_rdy_d;
            bp_hit_q      <= bp_hit_d;
            pulse_count_q <= pulse_count_d;
        end
    end

    assign bus.cpu_rdy     = cpu_rdy_q;
    assign bus.mode        = state_q;
    assign bus.bp_hit      = bp_hit_q;
    assign bus.pulse_count = pulse_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios plus random button/breakpoint
// traffic, checked every clock against a cycle-level behavioural model.
module tb_cpu_step_ctrl;

    localparam int unsigned DebN    = 4;
    localparam int unsigned SlowDiv = 10;
    localparam int unsigned FastDiv = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_step_ctrl_if bus ();
    cpu_step_ctrl_if wbus ();

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DebN),
        .SLOW_DIV       (SlowDiv),
        .FAST_DIV       (FastDiv)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Divide-by-one instance: pulses every clock so the counter wrap is reachable.
    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DebN),
        .SLOW_DIV       (1),
        .FAST_DIV       (1)
    ) u_wrap (
        .clk(clk),
        .rst(rst),
        .bus(wbus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode, clocks and pulses since the last entry, outputs.
    int m_mode, m_since, m_pulses, m_count;
    bit m_rdy, m_bp_hit;
    // Per-button raw history (index 0 newest), accepted level, press event.
    bit hist [2][DebN+1];
    bit lvl  [2];
    bit ev   [2];
    bit step_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // A level is accepted once the synchronized line (two clocks behind the
    // raw pin) has shown the opposite level for DebN clocks in a row.
    task automatic db_update(input int b, input bit raw);
        bit all_opp;
        all_opp = 1'b1;
        for (int i = 1; i <= int'(DebN); i++) if (hist[b][i] == lvl[b]) all_opp = 1'b0;
        ev[b] = 1'b0;
        if (all_opp) begin
            ev[b]  = (lvl[b] == 1'b1);
            lvl[b] = ~lvl[b];
        end
        for (int i = DebN; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = raw;
    endtask

    task automatic model_edge();
        bit rdy;
        int div;
        rdy = 1'b0;
        if (rst) begin
            m_mode = 0; m_since = 0; m_pulses = 0; m_count = 0;
            m_rdy = 1'b0; m_bp_hit = 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i <= int'(DebN); i++) hist[b][i] = 1'b1;
                lvl[b] = 1'b1;
                ev[b]  = 1'b0;
            end
        end else begin
            if (ev[1]) begin
                m_mode = (m_mode + 1) % 3;
                m_since = 0; m_pulses = 0; m_bp_hit = 1'b0;
            end else if (m_mode == 0) begin
                rdy = ev[0];
            end else begin
                div = (m_mode == 1) ? int'(SlowDiv) : int'(FastDiv);
                if (bus.bp_en && bus.cpu_addr == bus.bp_addr && m_pulses > 0) begin
                    m_mode = 0;
                    m_bp_hit = 1'b1;
                end else begin
                    m_since++;
                    if (m_since % div == 0) begin
                        rdy = 1'b1;
                        m_pulses++;
                    end
                end
            end
            m_rdy = rdy;
            if (rdy) m_count = (m_count + 1) % 65536;
            db_update(0, bus.btn_step_n);
            db_update(1, bus.btn_mode_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("rdy", 32'(bus.cpu_rdy), 32'(m_rdy));
        check_eq("mode", 32'(bus.mode), 32'(m_mode));
        check_eq("bp_hit", 32'(bus.bp_hit), 32'(m_bp_hit));
        check_eq("pulse_count", 32'(bus.pulse_count), 32'(m_count));
        if (step_addr && bus.cpu_rdy) bus.cpu_addr = bus.cpu_addr + 16'd1;
    endtask

    // which: 0 step, 1 mode, 2 step+mode together, 3 mode on the wrap instance.
    task automatic press(input int which, input int lo, input int hi);
        case (which)
            0: bus.btn_step_n = 1'b0;
            1: bus.btn_mode_n = 1'b0;
            2: begin bus.btn_step_n = 1'b0; bus.btn_mode_n = 1'b0; end
            default: wbus.btn_mode_n = 1'b0;
        endcase
        repeat (lo) tick();
        bus.btn_step_n  = 1'b1;
        bus.btn_mode_n  = 1'b1;
        wbus.btn_mode_n = 1'b1;
        repeat (hi) tick();
    endtask

    task automatic drive_step(input bit v, input int n, inout int pulses);
        bus.btn_step_n = v;
        repeat (n) begin
            tick();
            if (bus.cpu_rdy) pulses++;
        end
    endtask

    task automatic count_rdy(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (bus.cpu_rdy) cnt++;
        end
    endtask

    initial begin
        int n;
        int pulses;
        int p0;

        rst = 1'b1;
        bus.btn_step_n = 1'b1; bus.btn_mode_n = 1'b1;
        bus.cpu_addr = 16'hE000; bus.bp_addr = 16'h0000; bus.bp_en = 1'b0;
        wbus.btn_step_n = 1'b1; wbus.btn_mode_n = 1'b1;
        wbus.cpu_addr = 16'h0000; wbus.bp_addr = 16'h0000; wbus.bp_en = 1'b0;
        step_addr = 1'b0;
        repeat (3) tick();
        check_eq("reset_mode", 32'(bus.mode), 0);
        check_eq("reset_rdy", 32'(bus.cpu_rdy), 0);
        check_eq("reset_count", 32'(bus.pulse_count), 0);
        rst = 1'b0;

        // Short bouncy low, then a solid press: one pulse only.
        pulses = 0;
        drive_step(1'b0, 3, pulses);
        drive_step(1'b1, 1, pulses);
        drive_step(1'b0, 1, pulses);
        drive_step(1'b1, 1, pulses);
        drive_step(1'b0, 8, pulses);
        drive_step(1'b1, 12, pulses);
        check_eq("step_pulses", 32'(pulses), 1);
        check_eq("step_count", 32'(bus.pulse_count), 1);

        // Random bouncing on the step button while halted.
        repeat (200) begin
            if ($urandom_range(2) == 0) bus.btn_step_n = ~bus.btn_step_n;
            tick();
        end
        bus.btn_step_n = 1'b1;
        repeat (8) tick();

        // Mode cycling and pulse rates.
        press(1, 8, 8);
        check_eq("slow_mode", 32'(bus.mode), 1);
        repeat (5) tick();
        count_rdy(30, n);
        check_eq("slow_rate", 32'(n), 3);
        press(1, 8, 8);
        check_eq("fast_mode", 32'(bus.mode), 2);
        count_rdy(30, n);
        check_eq("fast_rate", 32'(n), 15);
        press(1, 8, 8);
        check_eq("halt_mode", 32'(bus.mode), 0);
        count_rdy(30, n);
        check_eq("halt_rate", 32'(n), 0);

        // Breakpoint in RUN_FAST.
        bus.cpu_addr = 16'hE000; bus.bp_addr = 16'hE005;
        press(1, 8, 8);
        press(1, 8, 8);
        check_eq("bp_pre_mode", 32'(bus.mode), 2);
        bus.bp_en = 1'b1;
        step_addr = 1'b1;
        n = 0;
        while (bus.mode != 2'd0 && n < 100) begin tick(); n++; end
        check_eq("bp_halt_mode", 32'(bus.mode), 0);
        check_eq("bp_halt_hit", 32'(bus.bp_hit), 1);
        check_eq("bp_halt_rdy", 32'(bus.cpu_rdy), 0);
        check_eq("bp_halt_addr", 32'(bus.cpu_addr), 32'hE005);

        // Resume from the breakpoint address.
        press(1, 8, 8);
        check_eq("res_mode", 32'(bus.mode), 1);
        check_eq("res_hit_clr", 32'(bus.bp_hit), 0);
        n = 0;
        while (!bus.cpu_rdy && n < 20) begin tick(); n++; end
        check_eq("res_first_pulse", 32'(bus.cpu_rdy), 1);
        check_eq("res_first_mode", 32'(bus.mode), 1);
        repeat (25) tick();
        check_eq("res_no_rehalt", 32'(bus.mode), 1);
        step_addr = 1'b0;
        bus.cpu_addr = 16'hE005;
        tick();
        check_eq("rehalt_mode", 32'(bus.mode), 0);
        check_eq("rehalt_hit", 32'(bus.bp_hit), 1);

        // Mode and step together in HALT: mode wins, step dropped.
        bus.bp_en = 1'b0;
        p0 = m_count;
        press(2, 8, 8);
        check_eq("both_mode", 32'(bus.mode), 1);
        check_eq("both_no_step", 32'(bus.pulse_count), 32'(p0));

        // Reset mid-count with a mode press half debounced.
        repeat (4) tick();
        bus.btn_mode_n = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_eq("rst_mode", 32'(bus.mode), 0);
        check_eq("rst_rdy", 32'(bus.cpu_rdy), 0);
        check_eq("rst_hit", 32'(bus.bp_hit), 0);
        check_eq("rst_count", 32'(bus.pulse_count), 0);
        rst = 1'b0;
        bus.btn_mode_n = 1'b1;
        repeat (10) tick();
        check_eq("rst_no_press", 32'(bus.mode), 0);

        // Random traffic.
        step_addr = 1'b1;
        repeat (1500) begin
            if ($urandom_range(5) == 0) bus.btn_step_n = ~bus.btn_step_n;
            if ($urandom_range(11) == 0) bus.btn_mode_n = ~bus.btn_mode_n;
            if ($urandom_range(39) == 0) begin
                if (bus.bp_en) begin
                    bus.bp_en = 1'b0;
                end else begin
                    bus.bp_addr = bus.cpu_addr + 16'($urandom_range(3));
                    bus.bp_en = 1'b1;
                end
            end
            if ($urandom_range(29) == 0) bus.cpu_addr = bus.bp_addr;
            rst = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0;
        bus.btn_step_n = 1'b1;
        bus.btn_mode_n = 1'b1;
        bus.bp_en = 1'b0;

        // pulse_count wrap on the divide-by-one instance: first pulse two
        // clocks after the press event, then one per clock.
        press(3, 8, 8);
        check_eq("wrap_run", 32'(wbus.mode), 1);
        n = 0;
        while (wbus.pulse_count != 16'hFFFF && n < 70000) begin tick(); n++; end
        check_eq("wrap_reach", 32'(wbus.pulse_count), 32'hFFFF);
        check_eq("wrap_cycles", 32'(n), 65526);
        tick();
        check_eq("wrap_zero", 32'(wbus.pulse_count), 0);
        check_eq("wrap_rdy", 32'(wbus.cpu_rdy), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning clocks a raw button must hold a level before it is accepted (10 ms at 25 MHz).
REQ-002 SHALL have parameter SLOW_DIV, default 12500000, meaning clocks between enable pulses in RUN_SLOW mode (2 Hz).
REQ-003 SHALL have parameter FAST_DIV, default 25, meaning clocks between enable pulses in RUN_FAST mode (1 MHz).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port btn_step_n, input, 1 bit: raw asynchronous step button, active-low.
REQ-007 SHALL have port btn_mode_n, input, 1 bit: raw asynchronous mode button, active-low.
REQ-008 SHALL have port cpu_addr, input, 16 bits: current CPU address bus.
REQ-009 SHALL have port bp_addr, input, 16 bits: breakpoint address, static while bp_en is high.
REQ-010 SHALL have port bp_en, input, 1 bit: breakpoint enable.
REQ-011 SHALL have port cpu_rdy, output, 1 bit: registered one-clock CPU enable pulse, wired to the CPU RDY input.
REQ-012 SHALL have port mode, output, 2 bits: current state, encoded HALT=0, RUN_SLOW=1, RUN_FAST=2.
REQ-013 SHALL have port bp_hit, output, 1 bit: sticky flag, set when a breakpoint forces HALT.
REQ-014 SHALL have port pulse_count, output, 16 bits: number of cpu_rdy pulses issued.

Function
REQ-015 SHALL pass each raw button through a 2-flop synchronizer, then a debouncer that updates its accepted level only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-016 SHALL generate exactly one one-clock press event per accepted 1->0 transition and none on release.
REQ-017 SHALL run a state machine on mode presses: HALT->RUN_SLOW->RUN_FAST->HALT, one transition per press.
REQ-018 SHALL, in HALT, assert cpu_rdy for exactly one clock, the clock after a step press event; cpu_rdy SHALL otherwise stay 0 in HALT.
REQ-019 SHALL ignore step presses in RUN_SLOW and RUN_FAST.
REQ-020 SHALL clear the divider counter on every state entry; in RUN_x, cpu_rdy SHALL pulse for one clock when the counter reaches x_DIV-1, then the counter SHALL wrap to 0.
REQ-021 SHALL, in RUN_x, treat cpu_addr==bp_addr with bp_en=1 as a breakpoint match: the next state is HALT, bp_hit is set, and no cpu_rdy pulse is issued in the match cycle.
REQ-022 SHALL mask breakpoint matching after each entry into RUN_x until that entry's first cpu_rdy pulse has been issued, so resuming from a breakpoint address is possible.
REQ-023 SHALL give a mode press priority over a breakpoint match in the same cycle.
REQ-024 SHALL, in HALT, give a mode press priority over a simultaneous step press; the step press is dropped.
REQ-025 SHALL clear bp_hit on any mode press.
REQ-026 SHALL increment pulse_count on every cpu_rdy pulse, wrapping from 0xFFFF to 0x0000.
REQ-027 SHALL drive all outputs from flops; there is no combinational path from an input to an output.

Reset
REQ-028 SHALL apply the following while rst=1: state=HALT, cpu_rdy=0, bp_hit=0, pulse_count=0, divider cleared, breakpoint mask set, debouncer accepted levels=1 (released), counters cleared.
REQ-029 SHALL, when rst is asserted mid-pulse or mid-debounce, take reset values on the next clock; no press event or pulse survives reset.

Structure
REQ-030 SHALL place the mode encoding constants (HALT, RUN_SLOW, RUN_FAST) in shared package cpu_dbg_pkg, also used by the display/LED logic.
REQ-031 SHALL implement synchronizer, debouncer and press-event generation in one sub-module, button_debounce (parameter DEBOUNCE_CYCLES), instantiated twice.

Verification
Test parameters: DEBOUNCE_CYCLES=4, SLOW_DIV=10, FAST_DIV=2.
REQ-032 SHALL cover: btn_step_n low for 3 clocks with bounces, then low for 8 clocks in HALT -> exactly one cpu_rdy pulse, pulse_count=1.
REQ-033 SHALL cover: one mode press -> mode=1, cpu_rdy pulses every 10 clocks; second press -> mode=2, pulses every 2 clocks; third press -> mode=0, no pulses.
REQ-034 SHALL cover: RUN_FAST with bp_en=1, bp_addr=0xE005, cpu_addr stepped +1 per pulse from 0xE000 -> HALT with cpu_addr=0xE005, bp_hit=1, no pulse in the match cycle.
REQ-035 SHALL cover: from that halt, a mode press -> bp_hit=0, mode=1, first pulse issued despite the address still matching, then re-halt only on the next match.
REQ-036 SHALL cover: mode and step presses in the same cycle in HALT -> mode=1, no step pulse; pulse_count preset near 0xFFFF wraps to 0x0000.
REQ-037 SHALL cover: rst pulsed during RUN_SLOW mid-count -> all outputs at reset values next clock, mode=0.
